muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 7 +
 rtl/muldiv_seq_div_step.sv | 16 +
 rtl/muldiv_seq.sv | 113 +++++++++++
 tb/tb_muldiv_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, opcodes and default width for the sequential multiply/divide unit.
package muldiv_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/muldiv_seq_div_step.sv
// div_step: one restoring shift-subtract step; remainder is always below the divisor, so WIDTH+1 bits suffice.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] trial, diff;
    assign trial = {rem_i, bit_i};
    assign diff = trial - {1'b0, dvs_i};
    assign q_o = ~diff[WIDTH];
    assign rem_o = q_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULTU/DIVU unit with architectural HI/LO registers and direct mthi/mtlo writes.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t state_q, state_d;
    logic [2*WIDTH-1:0] work_q, work_d, mul_nxt, div_nxt;
    logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, rem_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dbz_q, dbz_d, q_bit, last;
    logic [WIDTH:0] mul_sum;
    // work_q holds {accumulator/remainder, multiplier/dividend-being-shifted}
    assign mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, b_q} : '0);
    assign mul_nxt = {mul_sum, work_q[WIDTH-1:1]};
    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i(work_q[2*WIDTH-1:WIDTH]),
        .bit_i(work_q[WIDTH-1]),
        .dvs_i(b_q),
        .rem_o(rem_nxt),
        .q_o  (q_bit)
    );
    assign div_nxt = {rem_nxt, work_q[WIDTH-2:0], q_bit};
    assign last = cnt_q == CW'(WIDTH - 1);
    always_comb begin
        state_d = state_q;
        work_d = work_q;
        b_d = b_q;
        cnt_d = cnt_q;
        hi_d = hi_q;
        lo_d = lo_q;
        dbz_d = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d = {{WIDTH{1'b0}}, a};
                    b_d = b;
                    cnt_d = '0;
                    dbz_d = (op == OP_DIVU) && (b == '0);
                    if (op == OP_MULTU) begin
                        state_d = S_MUL;
                    end else if (b == '0) begin
                        state_d = S_DONE;
                        hi_d = a;
                        lo_d = '1;
                    end else begin
                        state_d = S_DIV;
                    end
                end else begin
                    hi_d = wr_hi ? wd : hi_q;
                    lo_d = wr_lo ? wd : lo_q;
                end
            end
            S_MUL: begin
                work_d = mul_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = S_DONE;
                    {hi_d, lo_d} = mul_nxt;
                end
            end
            S_DIV: begin
                work_d = div_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = S_DONE;
                    {hi_d, lo_d} = div_nxt;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q <= '0;
            b_q <= '0;
            cnt_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q <= work_d;
            b_q <= b_d;
            cnt_q <= cnt_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            dbz_q <= dbz_d;
        end
    end
    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
    assign done = state_q == S_DONE;
    assign dbz = done && dbz_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: random and directed MULTU/DIVU traffic checked every cycle against an arithmetic model.
module tb_muldiv_seq;
    localparam int W = 32;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, op = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic [W-1:0] a = '0, b = '0, wd = '0;
    logic busy, done, dbz;
    logic [W-1:0] hi, lo;
    int checks = 0, errors = 0;
    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h exp %h", nm, $time, act, exp);
        end
    endtask
    // Model: an accepted op finishes WIDTH edges later, result from plain * / %
    int m_left;
    logic m_done, m_dbz;
    logic [W-1:0] m_hi, m_lo;
    logic [2*W-1:0] m_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dbz <= 1'b0;
            m_hi <= '0;
            m_lo <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_dbz <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_res[2*W-1:W];
                m_lo <= m_res[W-1:0];
                m_done <= 1'b1;
            end
        end else if (start) begin
            if (!op) begin
                m_res <= (2*W)'(a) * (2*W)'(b);
                m_left <= W;
            end else if (b == 0) begin
                m_hi <= a;
                m_lo <= '1;
                m_done <= 1'b1;
                m_dbz <= 1'b1;
            end else begin
                m_res <= {a % b, a / b};
                m_left <= W;
            end
        end else begin
            if (wr_hi) m_hi <= wd;
            if (wr_lo) m_lo <= wd;
        end
    end
    always @(negedge clk) begin
        chk("busy", W'(busy), W'(m_left > 0));
        chk("done", W'(done), W'(m_done));
        chk("dbz", W'(dbz), W'(m_dbz));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    end
    task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        op = 1'($urandom);
        a = $urandom;
        b = $urandom;
    endtask
    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = 0;
        while (!done && n < 100) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask
    task automatic pulse_rst;
        #2 rst = 1'b1;
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_done", W'(done), 0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask
    initial begin
        int n, bc;
        #1 rst = 1'b1;
        #10;
        chk("init_hi", hi, 0);
        chk("init_lo", lo, 0);
        chk("init_busy", W'(busy), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, bc);
        chk("mul_max_busy_cycles", bc, 32);
        chk("mul_max_latency", n, 32);
        chk("mul_max_hi", hi, 32'hFFFF_FFFE);
        chk("mul_max_lo", lo, 32'h0000_0001);
        launch(1'b1, 100, 7);
        wait_done(n, bc);
        chk("div_lo", lo, 14);
        chk("div_hi", hi, 2);
        chk("div_dbz", W'(dbz), 0);
        launch(1'b1, 5, 0);
        wait_done(n, bc);
        chk("dbz_latency", n, 0);
        chk("dbz_hi", hi, 5);
        chk("dbz_lo", lo, 32'hFFFF_FFFF);
        chk("dbz_flag", W'(dbz), 1);
        launch(1'b0, 3, 4);
        repeat (9) @(negedge clk);
        pulse_rst();
        repeat (40) @(negedge clk);
        launch(1'b0, 6, 7);
        wait_done(n, bc);
        chk("mul67_lo", lo, 42);
        launch(1'b0, 2, 3);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op = 1'b1;
        wr_hi = 1'b1;
        wd = 32'hAAAA;
        @(negedge clk);
        start = 1'b0;
        wr_hi = 1'b0;
        chk("midop_hi_hold", hi, 0);
        chk("midop_lo_hold", lo, 42);
        wait_done(n, bc);
        chk("mul23_hi", hi, 0);
        chk("mul23_lo", lo, 6);
        repeat (2) @(negedge clk);
        chk("no_queue_busy", W'(busy), 0);
        @(negedge clk);
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wd = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        chk("mt_hi", hi, 32'h1234);
        chk("mt_lo", lo, 32'h1234);
        start = 1'b1;
        op = 1'b0;
        a = 2;
        b = 2;
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wd = 32'h5555;
        @(negedge clk);
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        chk("drop_write_hi", hi, 32'h1234);
        wait_done(n, bc);
        chk("mul22_lo", lo, 4);
        chk("mul22_hi", hi, 0);
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] x, y;
            if ($urandom_range(3) == 0) begin
                @(negedge clk);
                wr_hi = 1'($urandom);
                wr_lo = 1'($urandom);
                wd = $urandom;
                @(negedge clk);
                wr_hi = 1'b0;
                wr_lo = 1'b0;
            end
            x = ($urandom_range(3) == 0) ? W'($urandom_range(1000)) : W'($urandom);
            case ($urandom_range(3))
                0: y = '0;
                1: y = W'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            launch(1'($urandom), x, y);
            if ($urandom_range(19) == 0) begin
                repeat ($urandom_range(20)) @(negedge clk);
                if (busy) pulse_rst();
                repeat (35) @(negedge clk);
            end else begin
                wait_done(n, bc);
                start = 1'($urandom);
                wr_hi = 1'($urandom);
                wd = $urandom;
                @(negedge clk);
                start = 1'b0;
                wr_hi = 1'b0;
                repeat ($urandom_range(2)) @(negedge clk);
            end
        end
        repeat (40) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
